// File: rtl/id_ctrl_stage_if.sv
// Decode-to-control bundle interface: instruction fields and hazard inputs in,
// registered ID/EX control bundle and busy indication out.
interface id_ctrl_stage_if;
    logic       instr_valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall;
    logic       flush;

    logic       op1sel;
    logic       op2sel;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write_en;
    logic [1:0] wb_sel;
    logic [4:0] aluop;
    logic [2:0] branch_jump;
    logic [2:0] imm_sel;
    logic       valid_out;
    logic       illegal;
    logic       muldiv_start;
    logic       stall_out;

    modport master (
        output instr_valid, opcode, funct3, funct7, stall, flush,
        input  op1sel, op2sel, mem_write, mem_read, reg_write_en, wb_sel,
               aluop, branch_jump, imm_sel, valid_out, illegal, muldiv_start,
               stall_out
    );

    modport slave (
        input  instr_valid, opcode, funct3, funct7, stall, flush,
        output op1sel, op2sel, mem_write, mem_read, reg_write_en, wb_sel,
               aluop, branch_jump, imm_sel, valid_out, illegal, muldiv_start,
               stall_out
    );
endinterface

// File: rtl/id_ctrl_stage.sv
// RV32IM decode-stage control generator with the ID/EX control register and
// a busy counter that holds upstream while a multi-cycle MUL/DIV is in EX.
module id_ctrl_stage #(
    parameter bit          EN_M_EXT    = 1'b1,
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_LATENCY = 33,
    parameter int unsigned CNT_WIDTH   = 6
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    id_ctrl_stage_if.slave bus_io
);

    typedef enum logic [6:0] {
        OPC_LUI   = 7'b0110111,
        OPC_AUIPC = 7'b0010111,
        OPC_JAL   = 7'b1101111,
        OPC_JALR  = 7'b1100111,
        OPC_BR    = 7'b1100011,
        OPC_LOAD  = 7'b0000011,
        OPC_STORE = 7'b0100011,
        OPC_OPIMM = 7'b0010011,
        OPC_OP    = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic       op1sel;
        logic       op2sel;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write_en;
        logic [1:0] wb_sel;
        logic [4:0] aluop;
        logic [2:0] branch_jump;
        logic [2:0] imm_sel;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{
        op1sel:       1'b0,
        op2sel:       1'b0,
        mem_write:    1'b0,
        mem_read:     1'b0,
        reg_write_en: 1'b0,
        wb_sel:       2'b00,
        aluop:        5'b00000,
        branch_jump:  3'b010,
        imm_sel:      3'b000
    };

    // Counter holds the remaining EX cycles after the issue cycle, hence LAT-1.
    localparam logic [CNT_WIDTH-1:0] MUL_CNT = CNT_WIDTH'(MUL_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_CNT = CNT_WIDTH'(DIV_LATENCY - 1);

    ctrl_t                ctrl_d, ctrl_q;
    logic                 valid_d, valid_q;
    logic                 illegal_d, illegal_q;
    logic                 start_d, start_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    ctrl_t                dec_ctrl;
    logic                 dec_legal;
    logic                 dec_muldiv;
    logic                 dec_div;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [2:0]           imm_i;

    assign f3    = bus_io.funct3;
    assign f7    = bus_io.funct7;
    assign imm_i = {1'b1, f3 == 3'b011, f3[0] & ~(f3[2] & f3[1])};

    always_comb begin
        dec_ctrl   = BUBBLE;
        dec_legal  = 1'b1;
        dec_muldiv = 1'b0;
        dec_div    = 1'b0;
        case (opcode_e'(bus_io.opcode))
            OPC_LUI: begin
                dec_ctrl.reg_write_en = 1'b1;
                dec_ctrl.wb_sel       = 2'b10;
            end
            OPC_AUIPC: begin
                dec_ctrl.op1sel       = 1'b1;
                dec_ctrl.op2sel       = 1'b1;
                dec_ctrl.reg_write_en = 1'b1;
            end
            OPC_JAL: begin
                dec_ctrl.op1sel       = 1'b1;
                dec_ctrl.op2sel       = 1'b1;
                dec_ctrl.reg_write_en = 1'b1;
                dec_ctrl.wb_sel       = 2'b11;
                dec_ctrl.branch_jump  = 3'b011;
                dec_ctrl.imm_sel      = 3'b001;
            end
            OPC_JALR: begin
                dec_ctrl.op2sel       = 1'b1;
                dec_ctrl.reg_write_en = 1'b1;
                dec_ctrl.wb_sel       = 2'b11;
                dec_ctrl.branch_jump  = 3'b011;
                dec_ctrl.imm_sel      = imm_i;
            end
            OPC_BR: begin
                dec_ctrl.op1sel      = 1'b1;
                dec_ctrl.op2sel      = 1'b1;
                dec_ctrl.branch_jump = f3;
                dec_ctrl.imm_sel     = 3'b011;
            end
            OPC_LOAD: begin
                dec_ctrl.op2sel       = 1'b1;
                dec_ctrl.mem_read     = 1'b1;
                dec_ctrl.reg_write_en = 1'b1;
                dec_ctrl.wb_sel       = 2'b01;
            end
            OPC_STORE: begin
                dec_ctrl.op2sel    = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.imm_sel   = 3'b010;
            end
            OPC_OPIMM: begin
                dec_ctrl.op2sel       = 1'b1;
                dec_ctrl.reg_write_en = 1'b1;
                dec_ctrl.aluop        = {f3, f7[5], f7[0]};
                dec_ctrl.imm_sel      = imm_i;
            end
            OPC_OP: begin
                dec_ctrl.reg_write_en = 1'b1;
                dec_ctrl.aluop        = {f3, f7[5], f7[0]};
                case (f7)
                    7'b0000000: dec_legal = 1'b1;
                    7'b0100000: dec_legal = (f3 == 3'b000) || (f3 == 3'b101);
                    7'b0000001: begin
                        dec_legal  = EN_M_EXT;
                        dec_muldiv = EN_M_EXT;
                        dec_div    = f3[2];
                    end
                    default:    dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Priority: flush, then stall (hold), then draining a busy M op, then issue.
    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        start_d   = start_q;
        cnt_d     = cnt_q;
        if (bus_io.flush) begin
            ctrl_d    = BUBBLE;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            start_d   = 1'b0;
            cnt_d     = '0;
        end else if (!bus_io.stall) begin
            ctrl_d    = BUBBLE;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            start_d   = 1'b0;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end else if (bus_io.instr_valid && dec_legal) begin
                ctrl_d  = dec_ctrl;
                valid_d = 1'b1;
                start_d = dec_muldiv;
                if (dec_muldiv) begin
                    cnt_d = dec_div ? DIV_CNT : MUL_CNT;
                end
            end else if (bus_io.instr_valid) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q    <= BUBBLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus_io.op1sel       = ctrl_q.op1sel;
    assign bus_io.op2sel       = ctrl_q.op2sel;
    assign bus_io.mem_write    = ctrl_q.mem_write;
    assign bus_io.mem_read     = ctrl_q.mem_read;
    assign bus_io.reg_write_en = ctrl_q.reg_write_en;
    assign bus_io.wb_sel       = ctrl_q.wb_sel;
    assign bus_io.aluop        = ctrl_q.aluop;
    assign bus_io.branch_jump  = ctrl_q.branch_jump;
    assign bus_io.imm_sel      = ctrl_q.imm_sel;
    assign bus_io.valid_out    = valid_q;
    assign bus_io.illegal      = illegal_q;
    assign bus_io.muldiv_start = start_q;
    assign bus_io.stall_out    = (cnt_q != '0);

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Scoreboard bench for id_ctrl_stage: one instance with the M extension and one
// without, both fed identical stimulus and checked against a cycle model.
module tb_id_ctrl_stage;

    typedef struct packed {
        logic       op1sel;
        logic       op2sel;
        logic       memWrite;
        logic       memRead;
        logic       regWriteEn;
        logic [1:0] wbSel;
        logic [4:0] aluop;
        logic [2:0] branchJump;
        logic [2:0] immSel;
        logic       validOut;
        logic       illegal;
        logic       muldivStart;
        logic       stallOut;
    } expT;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    id_ctrl_stage_if busM ();
    id_ctrl_stage_if busN ();

    id_ctrl_stage #(.EN_M_EXT(1'b1), .MUL_LATENCY(2), .DIV_LATENCY(33), .CNT_WIDTH(6))
        dutM (.clk_i(clk), .rst_ni(rstN), .bus_io(busM));
    id_ctrl_stage #(.EN_M_EXT(1'b0), .MUL_LATENCY(2), .DIV_LATENCY(33), .CNT_WIDTH(6))
        dutN (.clk_i(clk), .rst_ni(rstN), .bus_io(busN));

    expT qM[$];
    expT qN[$];
    expT curM, curN;
    int  busyM, busyN;
    int  vectors = 0;
    int  miscompares = 0;
    bit  countWindow = 1'b0;
    int  stallHighCount = 0;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33;

    function automatic expT bubble();
        expT e = '0;
        e.branchJump = 3'd2;
        return e;
    endfunction

    function automatic logic [2:0] immIType(input logic [2:0] f3);
        case (f3)
            3'd3:       return 3'd7;
            3'd1, 3'd5: return 3'd5;
            default:    return 3'd4;
        endcase
    endfunction

    // Reference decode: returns the bundle, legality and EX latency (0 = not M op).
    task automatic refDecode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input bit enM, output expT e, output bit legal, output int lat);
        e = bubble();
        legal = 1'b1;
        lat = 0;
        case (opc)
            LUI:   begin e.regWriteEn = 1; e.wbSel = 2; end
            AUIPC: begin e.op1sel = 1; e.op2sel = 1; e.regWriteEn = 1; end
            JAL:   begin e.op1sel = 1; e.op2sel = 1; e.regWriteEn = 1; e.wbSel = 3;
                         e.branchJump = 3; e.immSel = 1; end
            JALR:  begin e.op2sel = 1; e.regWriteEn = 1; e.wbSel = 3; e.branchJump = 3;
                         e.immSel = immIType(f3); end
            BR:    begin e.op1sel = 1; e.op2sel = 1; e.branchJump = f3; e.immSel = 3; end
            LOAD:  begin e.op2sel = 1; e.memRead = 1; e.regWriteEn = 1; e.wbSel = 1; end
            STORE: begin e.op2sel = 1; e.memWrite = 1; e.immSel = 2; end
            OPIMM: begin e.op2sel = 1; e.regWriteEn = 1;
                         e.aluop = 5'(f3 * 4 + f7[5] * 2 + f7[0]); e.immSel = immIType(f3); end
            OP: begin
                e.regWriteEn = 1;
                e.aluop = 5'(f3 * 4 + f7[5] * 2 + f7[0]);
                if (f7 == 7'h00) legal = 1'b1;
                else if (f7 == 7'h20) legal = (f3 == 0) || (f3 == 5);
                else if (f7 == 7'h01) begin
                    legal = enM;
                    lat = (f3 >= 4) ? 33 : 2;
                end else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    endtask

    task automatic modelStep(inout expT cur, inout int busy, input bit enM, input bit flush,
                             input bit stall, input bit valid, input logic [6:0] opc,
                             input logic [2:0] f3, input logic [6:0] f7);
        expT d;
        bit  legal;
        int  lat;
        if (flush) begin
            cur = bubble();
            busy = 0;
        end else if (!stall) begin
            cur = bubble();
            if (busy > 0) busy--;
            else if (valid) begin
                refDecode(opc, f3, f7, enM, d, legal, lat);
                if (legal) begin
                    cur = d;
                    cur.validOut = 1'b1;
                    if (lat > 0) begin
                        cur.muldivStart = 1'b1;
                        busy = lat - 1;
                    end
                end else cur.illegal = 1'b1;
            end
        end
        cur.stallOut = (busy != 0);
    endtask

    function automatic expT sampleM();
        return {busM.op1sel, busM.op2sel, busM.mem_write, busM.mem_read, busM.reg_write_en,
                busM.wb_sel, busM.aluop, busM.branch_jump, busM.imm_sel, busM.valid_out,
                busM.illegal, busM.muldiv_start, busM.stall_out};
    endfunction

    function automatic expT sampleN();
        return {busN.op1sel, busN.op2sel, busN.mem_write, busN.mem_read, busN.reg_write_en,
                busN.wb_sel, busN.aluop, busN.branch_jump, busN.imm_sel, busN.valid_out,
                busN.illegal, busN.muldiv_start, busN.stall_out};
    endfunction

    function automatic void checkOutput(input string name, input expT act, input expT exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %06h expected %06h", name, $time, act, exp);
        end
    endfunction

    function automatic void checkValue(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    task automatic driveInputs(input bit valid, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input bit stall, input bit flush);
        busM.instr_valid = valid; busN.instr_valid = valid;
        busM.opcode = opc;        busN.opcode = opc;
        busM.funct3 = f3;         busN.funct3 = f3;
        busM.funct7 = f7;         busN.funct7 = f7;
        busM.stall = stall;       busN.stall = stall;
        busM.flush = flush;       busN.flush = flush;
    endtask

    // One clock of stimulus: the expected post-edge bundle is queued for the monitor.
    task automatic applyStimulus(input bit valid, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [6:0] f7, input bit stall = 0, input bit flush = 0);
        @(negedge clk);
        #1;
        driveInputs(valid, opc, f3, f7, stall, flush);
        modelStep(curM, busyM, 1'b1, flush, stall, valid, opc, f3, f7);
        modelStep(curN, busyN, 1'b0, flush, stall, valid, opc, f3, f7);
        qM.push_back(curM);
        qN.push_back(curN);
    endtask

    task automatic resetModels();
        curM = bubble(); curN = bubble();
        busyM = 0; busyN = 0;
        qM.push_back(curM);
        qN.push_back(curN);
    endtask

    always @(negedge clk) begin
        if (qM.size() > 0) checkOutput("dutM bundle", sampleM(), qM.pop_front());
        if (qN.size() > 0) checkOutput("dutN bundle", sampleN(), qN.pop_front());
        if (countWindow && busM.stall_out) stallHighCount++;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 7'h00, 3'd0, 7'h00);
    endtask

    initial begin
        int r;
        logic [6:0] opcTab [9];
        logic [6:0] opc, f7;
        logic [2:0] f3;

        opcTab = '{LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OPIMM, OP};
        rstN = 1'b0;
        driveInputs(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
        @(negedge clk); #1;
        resetModels();
        @(negedge clk); #2;
        rstN = 1'b1;

        // Basic decodes: ADD, SUB, SRAI, SLTIU, BLT, JALR, then one of each other format.
        applyStimulus(1, OP,    3'b000, 7'h00);
        applyStimulus(1, OP,    3'b000, 7'h20);
        applyStimulus(1, OPIMM, 3'b101, 7'h20);
        applyStimulus(1, OPIMM, 3'b011, 7'h00);
        applyStimulus(1, BR,    3'b100, 7'h00);
        applyStimulus(1, JALR,  3'b000, 7'h00);
        applyStimulus(1, LUI,   3'b010, 7'h11);
        applyStimulus(1, AUIPC, 3'b001, 7'h00);
        applyStimulus(1, JAL,   3'b111, 7'h7F);
        applyStimulus(1, LOAD,  3'b010, 7'h00);
        applyStimulus(1, STORE, 3'b010, 7'h00);
        applyStimulus(1, 7'h7F, 3'b000, 7'h00);
        applyStimulus(1, OP,    3'b001, 7'h20);
        idle(2);

        // DIV with the next instruction held valid: 32 stall cycles.
        stallHighCount = 0; countWindow = 1'b1;
        applyStimulus(1, OP, 3'b100, 7'h01);
        for (int i = 0; i < 40; i++) applyStimulus(1, OP, 3'b000, 7'h00);
        @(negedge clk); #1; countWindow = 1'b0;
        checkValue("div stall cycles", stallHighCount, 32);

        // MUL: single stall cycle.
        stallHighCount = 0; countWindow = 1'b1;
        applyStimulus(1, OP, 3'b000, 7'h01);
        for (int i = 0; i < 4; i++) applyStimulus(1, OP, 3'b110, 7'h00);
        @(negedge clk); #1; countWindow = 1'b0;
        checkValue("mul stall cycles", stallHighCount, 1);

        // DIV with 5 external stall cycles mid-busy stretches STALL_OUT to 37.
        stallHighCount = 0; countWindow = 1'b1;
        applyStimulus(1, OP, 3'b101, 7'h01);
        idle(10);
        for (int i = 0; i < 5; i++) applyStimulus(1, OP, 3'b000, 7'h00, 1'b1);
        for (int i = 0; i < 30; i++) applyStimulus(1, OP, 3'b000, 7'h00);
        @(negedge clk); #1; countWindow = 1'b0;
        checkValue("div+stall cycles", stallHighCount, 37);

        // Flush (together with stall) when 10 busy cycles remain, then a normal issue.
        applyStimulus(1, OP, 3'b110, 7'h01);
        idle(22);
        applyStimulus(1, OP, 3'b000, 7'h00, 1'b1, 1'b1);
        applyStimulus(1, LOAD, 3'b000, 7'h00);
        applyStimulus(1, OP, 3'b111, 7'h01);
        idle(3);

        // Asynchronous reset while a DIV is busy.
        applyStimulus(1, OP, 3'b100, 7'h01);
        idle(5);
        @(negedge clk); #1;
        checkValue("stall_out before reset", int'(busM.stall_out), 1);
        #2 rstN = 1'b0;
        #1 checkValue("stall_out async drop", int'(busM.stall_out), 0);
        driveInputs(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
        resetModels();
        @(negedge clk); #2;
        rstN = 1'b1;

        // Randomized mix of legal, illegal, stall and flush cycles.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            opc = (r < 9) ? opcTab[r] : 7'($urandom);
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            applyStimulus($urandom_range(0, 99) < 85, opc, f3, f7,
                          $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 4);
        end
        idle(2);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
